// File: rtl/stopwatch_counter_if.sv
// Control link from the clock-timer control FSM to the stopwatch counting core.
// valid is the run/hold level, fsm_reset is the clear-and-hold level.
interface stopwatch_counter_if;
  logic valid;
  logic fsm_reset;

  modport master (output valid, output fsm_reset);
  modport slave  (input  valid, input  fsm_reset);
endinterface

// File: rtl/stopwatch_counter.sv
// MM:SS.cc stopwatch core: prescaled centisecond time base feeding a six-digit
// BCD ripple cascade, run/pause/clear under the control FSM levels.
module stopwatch_counter #(
  parameter int unsigned TICK_DIV = 500000,
  parameter int unsigned CNT_W    = 19
) (
  input  logic                  clk,
  input  logic                  reset_n,
  stopwatch_counter_if.slave    ctrl,
  output logic [3:0]            cs_units,
  output logic [3:0]            cs_tens,
  output logic [3:0]            sec_units,
  output logic [3:0]            sec_tens,
  output logic [3:0]            min_units,
  output logic [3:0]            min_tens,
  output logic                  running,
  output logic                  tick,
  output logic                  overflow
);

  typedef enum logic [1:0] {
    CLEARED,
    RUNNING,
    PAUSED
  } state_t;

  localparam logic [CNT_W-1:0] PRESC_LAST = CNT_W'(TICK_DIV - 1);

  state_t           state;
  logic [CNT_W-1:0] presc;

  logic [3:0] nx_cs_units;
  logic [3:0] nx_cs_tens;
  logic [3:0] nx_sec_units;
  logic [3:0] nx_sec_tens;
  logic [3:0] nx_min_units;
  logic [3:0] nx_min_tens;
  logic       nx_wrap;

  // Next digit values if the count advances this cycle (full ripple carry).
  always_comb begin
    nx_cs_units  = cs_units;
    nx_cs_tens   = cs_tens;
    nx_sec_units = sec_units;
    nx_sec_tens  = sec_tens;
    nx_min_units = min_units;
    nx_min_tens  = min_tens;
    nx_wrap      = 1'b0;
    if (cs_units != 4'd9) begin
      nx_cs_units = cs_units + 4'd1;
    end else begin
      nx_cs_units = 4'd0;
      if (cs_tens != 4'd9) begin
        nx_cs_tens = cs_tens + 4'd1;
      end else begin
        nx_cs_tens = 4'd0;
        if (sec_units != 4'd9) begin
          nx_sec_units = sec_units + 4'd1;
        end else begin
          nx_sec_units = 4'd0;
          if (sec_tens != 4'd5) begin
            nx_sec_tens = sec_tens + 4'd1;
          end else begin
            nx_sec_tens = 4'd0;
            if (min_units != 4'd9) begin
              nx_min_units = min_units + 4'd1;
            end else begin
              nx_min_units = 4'd0;
              if (min_tens != 4'd5) begin
                nx_min_tens = min_tens + 4'd1;
              end else begin
                nx_min_tens = 4'd0;
                nx_wrap     = 1'b1;
              end
            end
          end
        end
      end
    end
  end

  // Run/pause/clear state machine with prescaler, digit registers and flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= CLEARED;
      presc     <= '0;
      cs_units  <= '0;
      cs_tens   <= '0;
      sec_units <= '0;
      sec_tens  <= '0;
      min_units <= '0;
      min_tens  <= '0;
      running   <= 1'b0;
      tick      <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      tick <= 1'b0;
      if (ctrl.fsm_reset) begin
        state     <= CLEARED;
        presc     <= '0;
        cs_units  <= '0;
        cs_tens   <= '0;
        sec_units <= '0;
        sec_tens  <= '0;
        min_units <= '0;
        min_tens  <= '0;
        running   <= 1'b0;
        overflow  <= 1'b0;
      end else begin
        case (state)
          CLEARED: begin
            if (ctrl.valid) begin
              state   <= RUNNING;
              running <= 1'b1;
            end
          end
          RUNNING: begin
            // Dropping valid freezes the prescaler, so a terminal count
            // reached here is advanced on the first running cycle after resume.
            if (!ctrl.valid) begin
              state   <= PAUSED;
              running <= 1'b0;
            end else if (presc == PRESC_LAST) begin
              presc     <= '0;
              cs_units  <= nx_cs_units;
              cs_tens   <= nx_cs_tens;
              sec_units <= nx_sec_units;
              sec_tens  <= nx_sec_tens;
              min_units <= nx_min_units;
              min_tens  <= nx_min_tens;
              tick      <= 1'b1;
              if (nx_wrap) begin
                overflow <= 1'b1;
              end
            end else begin
              presc <= presc + 1'b1;
            end
          end
          PAUSED: begin
            if (ctrl.valid) begin
              state   <= RUNNING;
              running <= 1'b1;
            end
          end
          default: begin
            state   <= CLEARED;
            running <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_stopwatch_counter.sv
// Scoreboard bench for stopwatch_counter with a short time base (TICK_DIV=4).
module tb_stopwatch_counter;

  localparam int unsigned TD = 4;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  stopwatch_counter_if ctrl ();

  logic [3:0] cs_units, cs_tens, sec_units, sec_tens, min_units, min_tens;
  logic       running, tick, overflow;

  stopwatch_counter #(.TICK_DIV(TD), .CNT_W(3)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .ctrl      (ctrl),
    .cs_units  (cs_units),
    .cs_tens   (cs_tens),
    .sec_units (sec_units),
    .sec_tens  (sec_tens),
    .min_units (min_units),
    .min_tens  (min_tens),
    .running   (running),
    .tick      (tick),
    .overflow  (overflow)
  );

  typedef struct {
    int unsigned edge_no;
    logic [23:0] dig;
    logic        ovf;
  } exp_t;

  exp_t        sb[$];
  int unsigned vectors     = 0;
  int unsigned miscompares = 0;
  int unsigned edges       = 0;

  // Reference model: state (0 cleared, 1 running, 2 paused), prescaler phase,
  // elapsed centiseconds and sticky overflow.
  int unsigned m_st  = 0;
  int unsigned m_ph  = 0;
  int unsigned m_n   = 0;
  logic        m_ovf = 1'b0;

  always @(posedge clk) edges <= edges + 1;

  function automatic logic [23:0] bcd(input int unsigned n);
    int unsigned cs, s, m;
    cs = n % 100;
    s  = (n / 100) % 60;
    m  = n / 6000;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), 4'(cs / 10), 4'(cs % 10)};
  endfunction

  function automatic logic [23:0] dig();
    return {min_tens, min_units, sec_tens, sec_units, cs_tens, cs_units};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every tick pops the oldest expectation; late expectations are missed ticks.
  always @(negedge clk) begin
    while (sb.size() != 0 && sb[0].edge_no < edges) begin
      vectors++;
      miscompares++;
      $display("FAIL missed_tick: no tick at edge %0d, required digits %h", sb[0].edge_no, sb[0].dig);
      void'(sb.pop_front());
    end
    if (tick === 1'b1) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_tick: tick at edge %0d digits %h, none required", edges, dig());
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("tick_edge", 32'(edges), 32'(e.edge_no));
        check("tick_value", {7'd0, overflow, dig()}, {7'd0, e.ovf, e.dig});
      end
    end
  end

  // Apply one cycle of control levels, update the model for the coming edge,
  // and return 1 time unit after that edge.
  task automatic step(input logic v, input logic r);
    ctrl.valid     = v;
    ctrl.fsm_reset = r;
    if (r) begin
      m_st = 0; m_ph = 0; m_n = 0; m_ovf = 1'b0;
    end else if (m_st == 0) begin
      if (v) m_st = 1;
    end else if (m_st == 1) begin
      if (!v) begin
        m_st = 2;
      end else if (m_ph == TD - 1) begin
        m_ph = 0;
        m_n  = (m_n + 1) % 360000;
        if (m_n == 0) m_ovf = 1'b1;
        sb.push_back('{edges + 1, bcd(m_n), m_ovf});
      end else begin
        m_ph++;
      end
    end else if (v) begin
      m_st = 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_to(input int unsigned target);
    int unsigned guard = 0;
    while (m_n != target && guard < 30000) begin
      step(1'b1, 1'b0);
      guard++;
    end
  endtask

  initial begin
    reset_n        = 1'b0;
    ctrl.valid     = 1'b0;
    ctrl.fsm_reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {5'd0, running, tick, overflow, dig()}, 32'd0);
    reset_n = 1'b1;
    step(1'b0, 1'b0);
    check("idle_after_reset", {5'd0, running, tick, overflow, dig()}, 32'd0);

    // first count: running one cycle after valid, ticks every TD cycles
    step(1'b1, 1'b0);
    check("running_rise", {30'd0, running, tick}, 32'b10);
    repeat (3) step(1'b1, 1'b0);
    check("no_early_tick", {31'd0, tick}, 32'd0);
    step(1'b1, 1'b0);
    check("first_tick", {27'd0, tick, cs_units}, {27'd0, 1'b1, 4'd1});
    repeat (TD) step(1'b1, 1'b0);
    check("second_tick", {27'd0, tick, cs_units}, {27'd0, 1'b1, 4'd2});
    repeat (TD) step(1'b1, 1'b0);
    check("third_tick", {27'd0, tick, cs_units}, {27'd0, 1'b1, 4'd3});

    // cascade cs -> sec
    run_to(100);
    check("one_second", {8'd0, dig()}, 32'h0000_0100);

    // clear priority over valid
    run_to(742);
    check("at_7_42", {8'd0, dig()}, 32'h0000_0742);
    repeat (3) step(1'b1, 1'b1);
    check("clear_hold", {6'd0, running, overflow, dig()}, 32'd0);
    step(1'b1, 1'b0);
    check("restart_running", {31'd0, running}, 32'd1);
    run_to(1);
    check("restart_count", {8'd0, dig()}, 32'h0000_0001);

    // cascade sec -> min
    run_to(6000);
    check("one_minute", {8'd0, dig()}, 32'h0001_0000);

    // pause with prescaler at 2, resume: next tick two running cycles later
    repeat (2) step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    check("pause_running", {31'd0, running}, 32'd0);
    repeat (19) step(1'b0, 1'b0);
    check("pause_frozen", {6'd0, running, tick, dig()}, 32'h0001_0000);
    step(1'b1, 1'b0);
    check("resume_running", {30'd0, running, tick}, 32'b10);
    step(1'b1, 1'b0);
    check("resume_no_tick", {31'd0, tick}, 32'd0);
    step(1'b1, 1'b0);
    check("resume_tick", {7'd0, tick, dig()}, {7'd0, 1'b1, 24'h01_0001});

    // overflow: preload 59:59.99 while paused
    step(1'b0, 1'b0);
    force dut.cs_units  = 4'd9;
    force dut.cs_tens   = 4'd9;
    force dut.sec_units = 4'd9;
    force dut.sec_tens  = 4'd5;
    force dut.min_units = 4'd9;
    force dut.min_tens  = 4'd5;
    #1;
    release dut.cs_units;
    release dut.cs_tens;
    release dut.sec_units;
    release dut.sec_tens;
    release dut.min_units;
    release dut.min_tens;
    m_n = 359999;
    step(1'b0, 1'b0);
    check("preload", {7'd0, overflow, dig()}, 32'h0059_5999);
    run_to(0);
    check("wrap", {6'd0, tick, overflow, dig()}, {6'd0, 2'b11, 24'd0});
    run_to(50);
    check("overflow_sticky_run", {7'd0, overflow, dig()}, {7'd0, 1'b1, 24'h00_0050});
    repeat (5) step(1'b0, 1'b0);
    check("overflow_sticky_pause", {30'd0, running, overflow}, 32'b01);
    step(1'b0, 1'b1);
    check("overflow_cleared", {6'd0, running, overflow, dig()}, 32'd0);

    // asynchronous reset between edges while running
    step(1'b1, 1'b0);
    run_to(3);
    while (m_ph != 2) step(1'b1, 1'b0);
    #1;
    reset_n = 1'b0;
    #1;
    check("async_reset_immediate", {5'd0, running, tick, overflow, dig()}, 32'd0);
    sb.delete();
    m_st = 0; m_ph = 0; m_n = 0; m_ovf = 1'b0;
    ctrl.valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    repeat (3) step(1'b0, 1'b0);
    check("stay_cleared", {6'd0, running, tick, dig()}, 32'd0);
    step(1'b1, 1'b0);
    check("run_after_reset", {31'd0, running}, 32'd1);
    run_to(2);
    check("count_after_reset", {8'd0, dig()}, 32'h0000_0002);

    repeat (2) step(1'b0, 1'b0);
    check("scoreboard_drain", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/stopwatch_counter.md
# stopwatch_counter

Time-base and BCD counting core that consumes the `valid` / `fsm_reset` control pair produced by the clock-timer control FSM. It runs, pauses or clears a MM:SS.cc stopwatch according to those levels. It presents six BCD digits to the display driver, plus status flags. It is the receiving end of the FSM control interface and is instantiated next to the FSM in the timer top level.

## Interface
- `TICK_DIV`, 500000, clock cycles per centisecond tick (100 Hz at 50 MHz); legal range ≥ 2.
- `CNT_W`, 19, width of the prescaler counter; must satisfy 2^CNT_W ≥ TICK_DIV.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `valid`  in  1  run enable from the control FSM (level): 1 = count, 0 = hold.
- `fsm_reset`  in  1  clear request from the control FSM (level): 1 = clear and hold at zero.
- `cs_units`, `cs_tens`  out  4 each  centisecond BCD digits (0–9 units, 0–9 tens).
- `sec_units`, `sec_tens`  out  4 each  second BCD digits (0–9 units, 0–5 tens).
- `min_units`, `min_tens`  out  4 each  minute BCD digits (0–9 units, 0–5 tens).
- `running`  out  1  1 while in state RUNNING.
- `tick`  out  1  one-cycle pulse on every cycle in which the centisecond count advances.
- `overflow`  out  1  sticky; set when the count wraps from 59:59.99 to 00:00.00.

## Operation
- **States:**
  - CLEARED: all digits 0, prescaler 0.
  - RUNNING: prescaler and digits advance.
  - PAUSED: everything frozen.
- **Transitions, evaluated each cycle with priority top to bottom:**
  - `fsm_reset`=1 → CLEARED from any state. This clears the digits, prescaler and `overflow`.
  - CLEARED & `valid`=1 → RUNNING.
  - RUNNING & `valid`=0 → PAUSED.
  - PAUSED & `valid`=1 → RUNNING.
  - Otherwise stay.
- `fsm_reset`=1 with `valid`=1 simultaneously: clear wins; the block stays CLEARED until `fsm_reset` drops.
- **Prescaler (RUNNING only):**
  - Increments each cycle.
  - On reaching TICK_DIV-1 it returns to 0 and generates an internal advance.
  - In PAUSED it holds its value, so no partial tick is lost across a pause.
- **Digit cascade on advance (ripple carry, all in the same cycle):**
  - `cs_units` 9→0 carries to `cs_tens`.
  - `cs_tens` 9→0 carries to `sec_units`.
  - `sec_units` 9→0 carries to `sec_tens`.
  - `sec_tens` 5→0 carries to `min_units`.
  - `min_units` 9→0 carries to `min_tens`.
  - `min_tens` 5→0 wraps the whole count to 00:00.00 and sets `overflow`.
- `overflow` stays at 1 through further counting and pauses. Only `fsm_reset` or `reset_n` clears it.
- Digits never take values outside their legal BCD range.

## Timing
- All outputs are registered.
- **Reset values (`reset_n`=0):**
  - State CLEARED, prescaler 0.
  - All six digits 4'd0.
  - `running`=0, `tick`=0, `overflow`=0.
- Reset is asserted asynchronously and released on the next `clk` edge. It takes effect mid-count with no partial update.
- **`valid` response:** `valid` sampled high at edge N (from CLEARED or PAUSED) → `running`=1 after edge N. The prescaler first increments at edge N+1.
- **First tick from CLEARED:** `tick` and `cs_units`=1 become visible after edge N+TICK_DIV, i.e. TICK_DIV cycles after `running` rises.
- **Tick spacing:** subsequent ticks are exactly TICK_DIV cycles apart while RUNNING.
- **Pause:** `valid` sampled low at edge M → `running`=0 after edge M, and no advance occurs at edge M. If the prescaler had reached TICK_DIV-1 at that edge, the advance is deferred to the first running cycle after resume.
- **`tick`:** high for exactly the one cycle following the edge at which the digits changed, and aligned with the new digit values.
- **Clear:** `fsm_reset` sampled high at edge K → digits 0, `overflow`=0 and `running`=0 after edge K.
- **Wrap:** digits show 00:00.00 and `overflow`=1 in the same cycle, after the edge that advances past 59:59.99.

## Test plan
- **Reset and first count** (TICK_DIV=4): apply `reset_n` low mid-simulation, then set `valid`=1. Required: all outputs 0 during reset; `running`=1 one cycle after `valid`; `tick` pulses every 4 cycles; `cs_units` reads 1,2,3… on successive ticks.
- **Cascade:** run 100 ticks → 00:01.00, `cs_tens`=0, `cs_units`=0, `sec_units`=1. Run 6000 ticks total → 01:00.00 (`sec_tens` rolls 5→0).
- **Pause/resume:** drop `valid` when the prescaler is at 2 for 20 cycles. Required: digits and `tick` frozen, `running`=0. Then raise `valid`. Required: the next tick arrives after 2 cycles of running, i.e. no lost or extra ticks.
- **Clear priority:** with digits at 00:07.42, assert `fsm_reset`=1 together with `valid`=1 for 3 cycles. Required: digits 0, `overflow`=0, `running`=0. Drop `fsm_reset` → `running`=1 next cycle, and counting restarts from 00:00.00.
- **Overflow:** preload by running to 59:59.99, then 1 tick. Required: 00:00.00 with `overflow`=1. `overflow` is still 1 after 50 more ticks and a pause, and is cleared by `fsm_reset`.
- **Async reset mid-count:** pulse `reset_n` low between clock edges while RUNNING. Required: outputs go to reset values immediately (before the next edge), and the block stays CLEARED until `valid` is sampled high.
